alu_reservation_station: RTL
============================

Name: alu_reservation_station

Overview:
Holds decoded integer/branch/jump instructions issued from the decoder until both source operands are available. Snoops the ALU and load-store result broadcasts (the common data bus) to wake up waiting operands. Each cycle it sends at most one ready entry to the ALU through its have_ins/ins_id/operand inputs. It sits directly upstream of the ALU and downstream of decode/rename.

Parameters:
RS_SIZE, 8, number of entries; the index width is log2(RS_SIZE).
ID_W, 3, reorder-buffer tag width; must match the ALU ins_id width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-low reset
rdy_in  input  1  global ready; low pauses the block
flush_pipline  input  1  mispredict flush
disp_valid  input  1  dispatch request
disp_id  input  ID_W  ROB tag of the dispatched instruction
disp_opcode/disp_funct3/disp_funct7  input  7/3/7  decoded fields
disp_imm  input  32  immediate
disp_shamt  input  6  shift amount
disp_pc  input  32  instruction PC
disp_rs1_rdy, disp_rs2_rdy  input  1 each  operand value valid at dispatch
disp_rs1_val, disp_rs2_val  input  32 each  operand values
disp_rs1_tag, disp_rs2_tag  input  ID_W each  producer tag when not ready
cdb_alu_rdy, cdb_alu_id, cdb_alu_val  input  1/ID_W/32  ALU broadcast
cdb_lsb_rdy, cdb_lsb_id, cdb_lsb_val  input  1/ID_W/32  load broadcast
rs_full  output  1  registered; high when occupancy == RS_SIZE
rs_count  output  log2(RS_SIZE)+1  registered occupancy
have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val, opcode, funct3, funct7, request_PC  output  1/ID_W/32/32/32/6/7/3/7/32  registered issue bundle to the ALU

Behaviour:
- Priority per rising edge: reset (rst_in==0) > flush > rdy_in low > normal operation.
- Reset: all entries not busy; rs_full=0; rs_count=0; have_ins=0; every issue-bundle output = 0.
- Flush: all entries are cleared and have_ins<=0. A dispatch in the flush cycle is dropped.
- rdy_in low: all state is held and have_ins<=0. Dispatch and broadcasts in that cycle are ignored.
- Entry fields: busy, id, op fields, pc, imm, shamt, and for each of the two operands {rdy, tag, val}.
- Dispatch:
  - Accepted when disp_valid && !rs_full. rs_full is the registered value, so it does not reflect a same-cycle issue.
  - The instruction is written into the lowest-index free entry.
  - An operand is captured as ready if disp_rsX_rdy is high, or if a broadcast in the same cycle matches disp_rsX_tag.
  - Dispatch with disp_valid high while rs_full is high is a protocol error; the block ignores it.
- Wakeup: every busy entry with a non-ready operand compares its tag against both broadcasts. On a match it captures the value and sets rdy. If both ports match the same tag, the ALU value wins.
- Issue:
  - Eligible entries are busy entries with both operands ready in registered state. A same-cycle wakeup does not make an entry eligible.
  - At most one entry is issued per edge. Its fields load the issue bundle, have_ins<=1, and the entry is freed the same edge.
  - If no entry is eligible, have_ins<=0 and the bundle holds its last values.
- Latency:
  - Dispatch with both operands ready at edge E0 → have_ins=1 after E0+1.
  - Operand woken at edge Ew → issue after Ew+1.
- rs_count update: +1 for an accepted dispatch, −1 for an issue; both in the same cycle leaves it unchanged. rs_full = (next count == RS_SIZE).
- Operands unused by an instruction (LUI/AUIPC/JAL rs1/rs2, I-type rs2) must be dispatched with rdy=1 by decode.

Optional Feature:
ALU_RS_OLDEST_FIRST_EN:
- Defined: each entry carries an age counter of log2(RS_SIZE)+1 bits. Dispatch sets the counter to 0; every accepted dispatch increments all other busy entries' counters. Issue selects the eligible entry with the largest age.
- Undefined: issue selects the lowest-index eligible entry and no age state exists.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles → have_ins=0, rs_count=0, rs_full=0, request_PC=0.
- Ready dispatch: ADDI id=2, rs1 ready val=5, imm=7 at edge E0 → after E0+1: have_ins=1, ins_id=2, rs1_val=5, imm_val=7; the ALU returns 12.
- Wakeup: ADD id=3, rs1 tag=1 not ready, rs2 ready=4; cdb_lsb_rdy=1, id=1, val=10 two cycles later → issue on the following edge with rs1_val=10, rs2_val=4.
- Same-cycle capture: dispatch with rs1 tag=5 while cdb_alu_rdy=1, id=5, val=0xDEAD → the entry issues next edge with rs1_val=0xDEAD.
- Full and flush: dispatch 8 non-ready entries → rs_full=1, a 9th dispatch is ignored, rs_count=8; pulse flush_pipline → rs_count=0, have_ins=0, and the earlier tags never issue.
- Ordering: entries 0..3 become ready at the same edge, dispatched in order 3,1,0,2 into slots 3,1,0,2 → with the macro, issue order is slots 3,1,0,2; without it, slots 0,1,2,3. Pulse rdy_in=0 mid-sequence → one cycle with have_ins=0, then the sequence resumes.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if: control, dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
interface alu_reservation_station_if #(
    parameter int RS_SIZE = 8,
    parameter int ID_W    = 3
);
    localparam int CW = $clog2(RS_SIZE) + 1;
    logic            rdy_in, flush_pipline;
    logic            disp_valid;
    logic [ID_W-1:0] disp_id;
    logic [6:0]      disp_opcode, disp_funct7;
    logic [2:0]      disp_funct3;
    logic [31:0]     disp_imm, disp_pc;
    logic [5:0]      disp_shamt;
    logic            disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0]     disp_rs1_val, disp_rs2_val;
    logic [ID_W-1:0] disp_rs1_tag, disp_rs2_tag;
    logic            cdb_alu_rdy, cdb_lsb_rdy;
    logic [ID_W-1:0] cdb_alu_id, cdb_lsb_id;
    logic [31:0]     cdb_alu_val, cdb_lsb_val;
    logic            rs_full;
    logic [CW-1:0]   rs_count;
    logic            have_ins;
    logic [ID_W-1:0] ins_id;
    logic [31:0]     rs1_val, rs2_val, imm_val, request_PC;
    logic [5:0]      shamt_val;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;

    modport slave (
        input  rdy_in, flush_pipline, disp_valid, disp_id, disp_opcode, disp_funct3, disp_funct7,
               disp_imm, disp_shamt, disp_pc, disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
               disp_rs1_tag, disp_rs2_tag, cdb_alu_rdy, cdb_alu_id, cdb_alu_val, cdb_lsb_rdy, cdb_lsb_id,
               cdb_lsb_val,
        output rs_full, rs_count, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val, opcode,
               funct3, funct7, request_PC
    );

    modport master (
        output rdy_in, flush_pipline, disp_valid, disp_id, disp_opcode, disp_funct3, disp_funct7,
               disp_imm, disp_shamt, disp_pc, disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
               disp_rs1_tag, disp_rs2_tag, cdb_alu_rdy, cdb_alu_id, cdb_alu_val, cdb_lsb_rdy, cdb_lsb_id,
               cdb_lsb_val,
        input  rs_full, rs_count, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val, opcode,
               funct3, funct7, request_PC
    );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds dispatched ALU ops until operands arrive over the CDB, issues one per cycle.
// Define ALU_RS_OLDEST_FIRST_EN to issue the oldest ready entry instead of the lowest-index one.
module alu_reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int ID_W    = 3
) (
    input logic                        clk_in,
    input logic                        rst_in,
    alu_reservation_station_if.slave   bus_io
);
    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic            busy;
        logic [ID_W-1:0] id;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     pc;
        logic [31:0]     imm;
        logic [5:0]      shamt;
        logic            rs1_rdy;
        logic [ID_W-1:0] rs1_tag;
        logic [31:0]     rs1_val;
        logic            rs2_rdy;
        logic [ID_W-1:0] rs2_tag;
        logic [31:0]     rs2_val;
`ifdef ALU_RS_OLDEST_FIRST_EN
        logic [CW-1:0]   age;
`endif
    } ent_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     rs1_val, rs2_val, imm, pc;
        logic [5:0]      shamt;
        logic [6:0]      opcode, funct7;
        logic [2:0]      funct3;
    } iss_t;

    ent_t            ent_q [RS_SIZE];
    ent_t            ent_d [RS_SIZE];
    iss_t            iss_q;
    logic            have_q, full_q, issue, accept;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   sel, slot;
    logic            alu_rdy, lsb_rdy;
    logic [ID_W-1:0] alu_id, lsb_id;
    logic [31:0]     alu_val, lsb_val;

    assign alu_rdy = bus_io.cdb_alu_rdy;
    assign alu_id  = bus_io.cdb_alu_id;
    assign alu_val = bus_io.cdb_alu_val;
    assign lsb_rdy = bus_io.cdb_lsb_rdy;
    assign lsb_id  = bus_io.cdb_lsb_id;
    assign lsb_val = bus_io.cdb_lsb_val;

    // Returns {rdy, val}; the ALU broadcast wins when both ports carry the tag.
    function automatic logic [32:0] snoop(input logic rdy, input logic [ID_W-1:0] tag, input logic [31:0] val);
        return rdy ? {1'b1, val} :
               (alu_rdy && alu_id == tag) ? {1'b1, alu_val} :
               (lsb_rdy && lsb_id == tag) ? {1'b1, lsb_val} : {1'b0, val};
    endfunction

    always_comb begin
        ent_d  = ent_q;
        issue  = 1'b0;
        sel    = '0;
        slot   = '0;
        accept = bus_io.disp_valid && !full_q;
`ifdef ALU_RS_OLDEST_FIRST_EN
        for (int i = 0; i < RS_SIZE; i++)
            if (ent_q[i].busy && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy && (!issue || ent_q[i].age > ent_q[sel].age)) begin
                issue = 1'b1;
                sel   = IW'(i);
            end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (ent_q[i].busy && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                issue = 1'b1;
                sel   = IW'(i);
            end
`endif
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!ent_q[i].busy)
                slot = IW'(i);
        for (int i = 0; i < RS_SIZE; i++) begin
            {ent_d[i].rs1_rdy, ent_d[i].rs1_val} = snoop(ent_q[i].rs1_rdy, ent_q[i].rs1_tag, ent_q[i].rs1_val);
            {ent_d[i].rs2_rdy, ent_d[i].rs2_val} = snoop(ent_q[i].rs2_rdy, ent_q[i].rs2_tag, ent_q[i].rs2_val);
`ifdef ALU_RS_OLDEST_FIRST_EN
            if (accept && ent_q[i].busy && ent_q[i].age != '1)
                ent_d[i].age = ent_q[i].age + 1'b1;
`endif
        end
        if (issue)
            ent_d[sel].busy = 1'b0;
        if (accept) begin
            ent_d[slot].busy    = 1'b1;
            ent_d[slot].id      = bus_io.disp_id;
            ent_d[slot].opcode  = bus_io.disp_opcode;
            ent_d[slot].funct3  = bus_io.disp_funct3;
            ent_d[slot].funct7  = bus_io.disp_funct7;
            ent_d[slot].pc      = bus_io.disp_pc;
            ent_d[slot].imm     = bus_io.disp_imm;
            ent_d[slot].shamt   = bus_io.disp_shamt;
            ent_d[slot].rs1_tag = bus_io.disp_rs1_tag;
            ent_d[slot].rs2_tag = bus_io.disp_rs2_tag;
            {ent_d[slot].rs1_rdy, ent_d[slot].rs1_val} = snoop(bus_io.disp_rs1_rdy, bus_io.disp_rs1_tag, bus_io.disp_rs1_val);
            {ent_d[slot].rs2_rdy, ent_d[slot].rs2_val} = snoop(bus_io.disp_rs2_rdy, bus_io.disp_rs2_tag, bus_io.disp_rs2_val);
`ifdef ALU_RS_OLDEST_FIRST_EN
            ent_d[slot].age     = '0;
`endif
        end
        count_d = count_q + CW'(accept) - CW'(issue);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent_q[i] <= '0;
            iss_q   <= '0;
            have_q  <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else if (bus_io.flush_pipline) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent_q[i] <= '0;
            have_q  <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else if (!bus_io.rdy_in) begin
            have_q <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
            full_q  <= count_d == CW'(RS_SIZE);
            have_q  <= issue;
            if (issue)
                iss_q <= '{id: ent_q[sel].id, rs1_val: ent_q[sel].rs1_val, rs2_val: ent_q[sel].rs2_val,
                           imm: ent_q[sel].imm, pc: ent_q[sel].pc, shamt: ent_q[sel].shamt,
                           opcode: ent_q[sel].opcode, funct7: ent_q[sel].funct7, funct3: ent_q[sel].funct3};
        end
    end

    assign bus_io.rs_full    = full_q;
    assign bus_io.rs_count   = count_q;
    assign bus_io.have_ins   = have_q;
    assign bus_io.ins_id     = iss_q.id;
    assign bus_io.rs1_val    = iss_q.rs1_val;
    assign bus_io.rs2_val    = iss_q.rs2_val;
    assign bus_io.imm_val    = iss_q.imm;
    assign bus_io.shamt_val  = iss_q.shamt;
    assign bus_io.opcode     = iss_q.opcode;
    assign bus_io.funct3     = iss_q.funct3;
    assign bus_io.funct7     = iss_q.funct7;
    assign bus_io.request_PC = iss_q.pc;
endmodule
